// File: rtl/md_sequencer.sv
// Multi-cycle multiply/divide sequencer owning HI/LO for the E stage.
// Results are computed at accept, held in pending registers, and committed after a fixed busy count.
module md_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        MDUse,
  output logic        Busy,
  output logic        Stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, stateNext;
  logic [CW-1:0] cnt, cntNext;
  logic [31:0]   pendHi, pendHiNext, pendLo, pendLoNext;
  logic [31:0]   hiReg, hiNext, loReg, loNext;
  logic          divZero, divZeroNext;

  logic [63:0] sprod, uprod;
  logic [31:0] divisor, absA, absB, qMag, rMag, sQuot, sRem, uQuot, uRem;
  logic        isMdOp;

  assign sprod = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign uprod = {32'b0, A} * {32'b0, B};

  // Signed divide goes through magnitudes so INT_MIN / -1 wraps to 0x80000000 with no special case.
  assign divisor = (B == 32'd0) ? 32'd1 : B;
  assign absA    = A[31] ? (32'd0 - A) : A;
  assign absB    = divisor[31] ? (32'd0 - divisor) : divisor;
  assign qMag    = absA / absB;
  assign rMag    = absA % absB;
  assign sQuot   = (A[31] ^ divisor[31]) ? (32'd0 - qMag) : qMag;
  assign sRem    = A[31] ? (32'd0 - rMag) : rMag;
  assign uQuot   = A / divisor;
  assign uRem    = A % divisor;

  assign isMdOp = (MDOp >= OP_MULT) && (MDOp <= OP_DIVU);
  assign Busy   = (state == BUSY);
  assign Stall  = MDUse & (Busy | (Start & isMdOp));
  assign HI     = hiReg;
  assign LO     = loReg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      pendHi  <= '0;
      pendLo  <= '0;
      hiReg   <= '0;
      loReg   <= '0;
      divZero <= 1'b0;
    end else begin
      state   <= stateNext;
      cnt     <= cntNext;
      pendHi  <= pendHiNext;
      pendLo  <= pendLoNext;
      hiReg   <= hiNext;
      loReg   <= loNext;
      divZero <= divZeroNext;
    end
  end

  always_comb begin
    stateNext   = state;
    cntNext     = cnt;
    pendHiNext  = pendHi;
    pendLoNext  = pendLo;
    hiNext      = hiReg;
    loNext      = loReg;
    divZeroNext = divZero;
    case (state)
      IDLE: begin
        if (Start) begin
          case (MDOp)
            OP_MULT: begin
              stateNext   = BUSY;
              cntNext     = CW'(MULT_CYCLES);
              pendHiNext  = sprod[63:32];
              pendLoNext  = sprod[31:0];
              divZeroNext = 1'b0;
            end
            OP_MULTU: begin
              stateNext   = BUSY;
              cntNext     = CW'(MULT_CYCLES);
              pendHiNext  = uprod[63:32];
              pendLoNext  = uprod[31:0];
              divZeroNext = 1'b0;
            end
            OP_DIV: begin
              stateNext   = BUSY;
              cntNext     = CW'(DIV_CYCLES);
              pendHiNext  = sRem;
              pendLoNext  = sQuot;
              divZeroNext = (B == 32'd0);
            end
            OP_DIVU: begin
              stateNext   = BUSY;
              cntNext     = CW'(DIV_CYCLES);
              pendHiNext  = uRem;
              pendLoNext  = uQuot;
              divZeroNext = (B == 32'd0);
            end
            OP_MTHI: hiNext = A;
            OP_MTLO: loNext = A;
            default: ;
          endcase
        end
      end
      BUSY: begin
        cntNext = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          stateNext = IDLE;
          if (!divZero) begin
            hiNext = pendHi;
            loNext = pendLo;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

endmodule
